flit_sink_checker: RTL and testbench

- Self-checking flit consumer. It attaches to one router output port, in place of the plain sink on the final router's port 0.
- It completes the req/ack handshake for each incoming flit, with programmable back-pressure.
- It checks each payload against an expected incrementing sequence and keeps received/error counters.
- It raises done once the expected number of flits has arrived, so multi-router benches can self-terminate.

---
 rtl/flit_sink_checker_pkg.sv | 21 ++
 rtl/handshake_rx_fsm.sv | 68 ++++++
 rtl/flit_sink_checker.sv | 77 +++++++
 tb/tb_flit_sink_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_sink_checker_pkg.sv
// Shared NoC definitions: flit width, the four-phase handshake state encoding
// used by both source and sink FSMs, and a saturating-increment helper.
package flit_sink_checker_pkg;

    localparam int FLIT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        ACCEPT   = 2'd2,
        WAIT_LOW = 2'd3
    } hs_state_t;

    // Increments value but sticks at the all-ones value of a bits-wide counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned bits);
        logic [31:0] max_val;
        max_val = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/handshake_rx_fsm.sv
// Four-phase return-to-zero receiver: optional ACK_DELAY wait before ack,
// one-cycle accept pulse on the edge where ack rises.
module handshake_rx_fsm
    import flit_sink_checker_pkg::*;
#(
    parameter int ACK_DELAY = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic ack,
    output logic accept
);

    localparam logic [7:0] DELAY_INIT = 8'(ACK_DELAY);

    hs_state_t  state, state_next;
    logic [7:0] delay_cnt, delay_cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            delay_cnt <= '0;
        end else begin
            state     <= state_next;
            delay_cnt <= delay_cnt_next;
        end
    end

    // accept marks the transition into ACCEPT so data is captured while req is known high.
    always_comb begin
        state_next     = state;
        delay_cnt_next = delay_cnt;
        accept         = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    delay_cnt_next = DELAY_INIT;
                    if (ACK_DELAY > 0) begin
                        state_next = DELAY;
                    end else begin
                        state_next = ACCEPT;
                        accept     = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (!req) begin
                    state_next     = IDLE;
                    delay_cnt_next = '0;
                end else if (delay_cnt == 8'd1) begin
                    state_next     = ACCEPT;
                    delay_cnt_next = '0;
                    accept         = 1'b1;
                end else begin
                    delay_cnt_next = delay_cnt - 8'd1;
                end
            end
            ACCEPT, WAIT_LOW: begin
                state_next = req ? WAIT_LOW : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ack = (state == ACCEPT) || (state == WAIT_LOW);

endmodule

// File: rtl/flit_sink_checker.sv
// Self-checking flit sink: completes the handshake, checks payloads against an
// incrementing sequence that resynchronises after errors, and flags done.
module flit_sink_checker
    import flit_sink_checker_pkg::*;
#(
    parameter int ID             = 0,
    parameter int SIZE           = FLIT_W,
    parameter int PAYLOAD_BASE   = 10,
    parameter int EXPECTED_FLITS = 4,
    parameter int ACK_DELAY      = 0,
    parameter int COUNT_BITS     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    output logic                  ack,
    input  logic [SIZE-1:0]       data,
    output logic [COUNT_BITS-1:0] flit_count,
    output logic [COUNT_BITS-1:0] error_count,
    output logic [SIZE-1:0]       last_data,
    output logic                  error,
    output logic                  done
);

    logic                  accept;
    logic                  mismatch;
    logic [SIZE-1:0]       expected;
    logic [COUNT_BITS-1:0] flit_count_next;
    logic [COUNT_BITS-1:0] error_count_next;

    handshake_rx_fsm #(
        .ACK_DELAY (ACK_DELAY)
    ) u_rx_fsm (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .ack    (ack),
        .accept (accept)
    );

    assign mismatch         = accept && (data != expected);
    assign flit_count_next  = COUNT_BITS'(sat_inc(32'(flit_count), COUNT_BITS));
    assign error_count_next = COUNT_BITS'(sat_inc(32'(error_count), COUNT_BITS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_count  <= '0;
            error_count <= '0;
            last_data   <= '0;
            error       <= 1'b0;
            done        <= 1'b0;
            expected    <= SIZE'(PAYLOAD_BASE);
        end else if (accept) begin
            last_data  <= data;
            flit_count <= flit_count_next;
            // Follow the received stream so one bad flit costs exactly one error.
            expected   <= data + SIZE'(1);
            if (mismatch) begin
                error_count <= error_count_next;
                error       <= 1'b1;
            end
            if (32'(flit_count_next) == 32'(EXPECTED_FLITS)) begin
                done <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && mismatch) begin
            $display("flit_sink_checker[%0d]: payload error on flit %0d, expected %0d, received %0d",
                     ID, flit_count, expected, data);
        end
    end
`endif

endmodule

// File: tb/tb_flit_sink_checker.sv
// Bench for flit_sink_checker: three configurations driven by directed and
// random handshakes, compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_flit_sink_checker;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req  [N];
    logic [7:0] data [N];
    bit         chk_en = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         lat;

    logic       ack0, ack1, ack2, err0, err1, err2, dn0, dn1, dn2;
    logic [7:0] fc0, fc1, ec0, ec1, ld0, ld1, ld2;
    logic [1:0] fc2, ec2;

    always #5 clk = ~clk;

    flit_sink_checker #(.ID(0)) u_a (
        .clk(clk), .reset(reset_n), .req(req[0]), .ack(ack0), .data(data[0]),
        .flit_count(fc0), .error_count(ec0), .last_data(ld0), .error(err0), .done(dn0));

    flit_sink_checker #(.ID(1), .ACK_DELAY(3)) u_b (
        .clk(clk), .reset(reset_n), .req(req[1]), .ack(ack1), .data(data[1]),
        .flit_count(fc1), .error_count(ec1), .last_data(ld1), .error(err1), .done(dn1));

    flit_sink_checker #(.ID(2), .PAYLOAD_BASE(254), .EXPECTED_FLITS(3), .COUNT_BITS(2)) u_c (
        .clk(clk), .reset(reset_n), .req(req[2]), .ack(ack2), .data(data[2]),
        .flit_count(fc2), .error_count(ec2), .last_data(ld2), .error(err2), .done(dn2));

    function automatic int p_delay(input int i); return (i == 1) ? 3 : 0;     endfunction
    function automatic int p_base (input int i); return (i == 2) ? 254 : 10;  endfunction
    function automatic int p_max  (input int i); return (i == 2) ? 3 : 255;   endfunction
    function automatic int p_exp  (input int i); return (i == 2) ? 3 : 4;     endfunction

    function automatic logic get_ack(input int i);
        case (i)
            0:       return ack0;
            1:       return ack1;
            default: return ack2;
        endcase
    endfunction

    // Transaction-level model: a flit is taken once req has been seen high on
    // delay+1 consecutive edges while the sink is free; ack then stays up
    // until an edge samples req low.
    bit         m_busy [N];
    int         m_run  [N];
    int         m_fc   [N];
    int         m_ec   [N];
    logic [7:0] m_ld   [N];
    logic [7:0] m_exp  [N];
    bit         m_err  [N];
    bit         m_done [N];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] <= 1'b0; m_run[i] <= 0; m_fc[i] <= 0; m_ec[i] <= 0;
                m_ld[i] <= 8'd0; m_exp[i] <= 8'(p_base(i)); m_err[i] <= 1'b0; m_done[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_busy[i]) begin
                    if (!req[i]) m_busy[i] <= 1'b0;
                end else if (!req[i]) begin
                    m_run[i] <= 0;
                end else if (m_run[i] < p_delay(i)) begin
                    m_run[i] <= m_run[i] + 1;
                end else begin
                    m_run[i]  <= 0;
                    m_busy[i] <= 1'b1;
                    m_fc[i]   <= (m_fc[i] < p_max(i)) ? m_fc[i] + 1 : m_fc[i];
                    m_ld[i]   <= data[i];
                    m_exp[i]  <= data[i] + 8'd1;
                    if (data[i] != m_exp[i]) begin
                        m_err[i] <= 1'b1;
                        m_ec[i]  <= (m_ec[i] < p_max(i)) ? m_ec[i] + 1 : m_ec[i];
                    end
                    if (m_fc[i] + 1 == p_exp(i)) m_done[i] <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int i, input logic a, input logic [7:0] f, input logic [7:0] e,
                       input logic [7:0] l, input logic er, input logic d);
        chk($sformatf("ack%0d", i),         32'(a),  32'(m_busy[i]));
        chk($sformatf("flit_count%0d", i),  32'(f),  32'(m_fc[i]));
        chk($sformatf("error_count%0d", i), 32'(e),  32'(m_ec[i]));
        chk($sformatf("last_data%0d", i),   32'(l),  32'(m_ld[i]));
        chk($sformatf("error%0d", i),       32'(er), 32'(m_err[i]));
        chk($sformatf("done%0d", i),        32'(d),  32'(m_done[i]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, ack0, fc0, ec0, ld0, err0, dn0);
            cmp(1, ack1, fc1, ec1, ld1, err1, dn1);
            cmp(2, ack2, {6'd0, fc2}, {6'd0, ec2}, ld2, err2, dn2);
        end
    end

    // Called at posedge+1; returns at posedge+1 once ack has dropped again.
    task automatic send(input int i, input logic [7:0] d, input int hold, output int edges);
        int k;
        data[i] = d;
        req[i]  = 1'b1;
        k = 0;
        while (!get_ack(i) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        edges = k;
        chk($sformatf("ack_rise%0d", i), 32'(get_ack(i)), 32'd1);
        repeat (hold) begin @(posedge clk); #1; end
        req[i]  = 1'b0;
        data[i] = 8'($urandom);
        k = 0;
        while (get_ack(i) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("ack_fall%0d", i), 32'(get_ack(i)), 32'd0);
    endtask

    task automatic abandon(input int i, input int edges);
        data[i] = 8'($urandom);
        req[i]  = 1'b1;
        repeat (edges) begin @(posedge clk); #1; end
        req[i] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk($sformatf("abandon_ack%0d", i), 32'(get_ack(i)), 32'd0);
        end
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin req[i] = 1'b0; data[i] = 8'd0; end
        #2 reset_n = 1'b0;
        #1 chk_en = 1'b1;
        chk("reset_ack",  32'(ack0), 32'd0);
        chk("reset_fc",   32'(fc0),  32'd0);
        chk("reset_ld",   32'(ld0),  32'd0);
        chk("reset_done", 32'(dn0),  32'd0);
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;

        // Single flit: ack and counters one edge after req.
        req[0] = 1'b1; data[0] = 8'd10;
        @(posedge clk); #1;
        chk("single_ack", 32'(ack0), 32'd1);
        chk("single_fc",  32'(fc0),  32'd1);
        chk("single_ld",  32'(ld0),  32'd10);
        chk("single_err", 32'(err0), 32'd0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        chk("single_ack_low", 32'(ack0), 32'd0);

        send(0, 8'd11, 0, lat);
        chk("lat_delay0", 32'(lat), 32'd1);
        send(0, 8'd12, 1, lat);
        chk("pre_done", 32'(dn0), 32'd0);
        send(0, 8'd13, 0, lat);
        chk("stream_done", 32'(dn0), 32'd1);
        chk("stream_fc",   32'(fc0), 32'd4);
        chk("stream_ec",   32'(ec0), 32'd0);

        // Mismatch and resync.
        pulse_reset();
        send(0, 8'd10, 0, lat);
        send(0, 8'd15, 0, lat);
        chk("mis_err", 32'(err0), 32'd1);
        chk("mis_ec",  32'(ec0),  32'd1);
        send(0, 8'd16, 2, lat);
        chk("resync_ec", 32'(ec0), 32'd1);
        chk("resync_fc", 32'(fc0), 32'd3);

        // Async reset while ack is high, then the held req is a fresh first flit.
        req[0] = 1'b1; data[0] = 8'd17;
        @(posedge clk); #1;
        chk("pre_rst_done", 32'(dn0), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ack",  32'(ack0), 32'd0);
        chk("arst_fc",   32'(fc0),  32'd0);
        chk("arst_ec",   32'(ec0),  32'd0);
        chk("arst_err",  32'(err0), 32'd0);
        chk("arst_done", 32'(dn0),  32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack", 32'(ack0), 32'd1);
        chk("post_rst_fc",  32'(fc0),  32'd1);
        chk("post_rst_ec",  32'(ec0),  32'd1);
        chk("post_rst_ld",  32'(ld0),  32'd17);
        req[0] = 1'b0;
        @(posedge clk); #1;

        // ACK_DELAY=3 latency and abandoned request.
        send(1, 8'd10, 0, lat);
        chk("lat_delay3", 32'(lat), 32'd4);
        abandon(1, 2);
        chk("abandon_fc", 32'(fc1), 32'd1);
        send(1, 8'd11, 0, lat);
        chk("after_abandon_ec", 32'(ec1), 32'd0);

        // Payload wrap and 2-bit counter saturation.
        for (int v = 0; v < 5; v++) send(2, 8'(254 + v), 0, lat);
        chk("wrap_ec",   32'(ec2), 32'd0);
        chk("sat_fc",    32'(fc2), 32'd3);
        chk("wrap_done", 32'(dn2), 32'd1);

        // Random traffic, mostly in-sequence with occasional bad payloads.
        for (int r = 0; r < 80; r++) begin
            int i;
            logic [7:0] d;
            i = $urandom_range(0, N - 1);
            d = ($urandom_range(0, 4) == 0) ? 8'($urandom) : m_exp[i];
            if (i == 1 && $urandom_range(0, 4) == 0) abandon(1, $urandom_range(1, 3));
            else send(i, d, $urandom_range(0, 3), lat);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
